// File: rtl/memory.sv
// memory -- memory-access pipeline stage.
//
// Sits directly downstream of the execute stage. Non-memory instructions are
// registered through to writeback with one cycle of latency. Loads and stores
// are issued as RV64 doubleword transactions on a valid / addr_ok / data_ok
// data bus, and upstream is stalled while a transaction is outstanding.
//
// Ports:
//   clk       in   clock
//   reset     in   synchronous, active-high reset
//   dataE     in   execute result, store data and control
//   valid_e   in   dataE holds a live instruction this cycle
//   dreq      out  data-bus request (valid, addr, size, strobe, data)
//   dresp     in   data-bus response (addr_ok, data_ok, data)
//   dataM     out  registered result / regwrite / dst for writeback
//   valid_m   out  dataM is live (registered)
//   stall     out  upstream must hold dataE this cycle (combinational)
//   misalign  out  one-cycle pulse on a misaligned access (registered)

package memory_pkg;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        logic [4:0] dst;
        logic       jump;
    } execute_ctl_t;

    typedef struct packed {
        logic [63:0]  result;
        logic [63:0]  memdata;
        execute_ctl_t ctl;
    } execute_data_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic       regwrite;
        logic [4:0] dst;
    } memory_ctl_t;

    typedef struct packed {
        logic [63:0] result;
        memory_ctl_t ctl;
    } memory_data_t;

endpackage

module memory
    import memory_pkg::*;
#(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  execute_data_t dataE,
    input  logic          valid_e,
    output dbus_req_t     dreq,
    input  dbus_resp_t    dresp,
    output memory_data_t  dataM,
    output logic          valid_m,
    output logic          stall,
    output logic          misalign
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10
    } state_t;

    state_t       state_r;
    state_t       state_next_s;

    logic [63:0]  hold_addr_r;
    logic [63:0]  hold_wdata_r;
    logic [7:0]   hold_strobe_r;
    logic         hold_write_r;
    logic         hold_regwrite_r;
    logic [4:0]   hold_dst_r;
    logic         dreq_valid_r;

    memory_data_t data_m_r;
    memory_data_t data_m_next_s;
    logic         valid_m_r;
    logic         valid_m_next_s;
    logic         misalign_r;
    logic         misalign_next_s;

    logic         is_mem_s;
    logic         misalign_hit_s;
    logic         accept_s;
    logic         complete_s;
    logic         stall_s;
    logic         unused_s;

    function automatic logic dword_misaligned(input logic [63:0] addr);
        return (addr[2:0] != 3'b000);
    endfunction

    // Classify the incoming instruction and detect the completing bus cycle.
    always_comb begin
        is_mem_s       = valid_e & (dataE.ctl.memread | dataE.ctl.memwrite);
        misalign_hit_s = is_mem_s & ALIGN_CHECK & dword_misaligned(dataE.result);
        accept_s       = (state_r == IDLE) & is_mem_s & ~misalign_hit_s;
        // data_ok finishes the access from ADDR as well: the bus never
        // returns data for an address it has not taken.
        complete_s     = (state_r != IDLE) & dresp.data_ok;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = ADDR;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ADDR: begin
                if (dresp.data_ok) begin
                    state_next_s = IDLE;
                end else if (dresp.addr_ok) begin
                    state_next_s = DATA;
                end else begin
                    state_next_s = ADDR;
                end
            end
            DATA: begin
                if (dresp.data_ok) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DATA;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Output logic: stall and the next values of the writeback registers.
    always_comb begin
        stall_s         = 1'b0;
        valid_m_next_s  = 1'b0;
        misalign_next_s = 1'b0;
        data_m_next_s   = data_m_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    stall_s = 1'b1;
                end else if (misalign_hit_s) begin
                    valid_m_next_s             = 1'b1;
                    misalign_next_s            = 1'b1;
                    data_m_next_s.result       = dataE.result;
                    data_m_next_s.ctl.regwrite = 1'b0;
                    data_m_next_s.ctl.dst      = dataE.ctl.dst;
                end else if (valid_e) begin
                    valid_m_next_s             = 1'b1;
                    data_m_next_s.result       = dataE.result;
                    data_m_next_s.ctl.regwrite = dataE.ctl.regwrite;
                    data_m_next_s.ctl.dst      = dataE.ctl.dst;
                end else begin
                    valid_m_next_s = 1'b0;
                end
            end
            ADDR, DATA: begin
                if (complete_s) begin
                    valid_m_next_s             = 1'b1;
                    data_m_next_s.result       = hold_write_r ? hold_addr_r : dresp.data;
                    data_m_next_s.ctl.regwrite = hold_regwrite_r;
                    data_m_next_s.ctl.dst      = hold_dst_r;
                end else begin
                    stall_s = 1'b1;
                end
            end
            default: stall_s = 1'b0;
        endcase
    end

    // Hold registers, bus-request valid and writeback output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_addr_r     <= 64'h0;
            hold_wdata_r    <= 64'h0;
            hold_strobe_r   <= 8'h00;
            hold_write_r    <= 1'b0;
            hold_regwrite_r <= 1'b0;
            hold_dst_r      <= 5'd0;
            dreq_valid_r    <= 1'b0;
            data_m_r        <= '0;
            valid_m_r       <= 1'b0;
            misalign_r      <= 1'b0;
        end else begin
            if (accept_s) begin
                hold_addr_r     <= dataE.result;
                hold_wdata_r    <= dataE.memdata;
                hold_strobe_r   <= dataE.ctl.memwrite ? 8'hFF : 8'h00;
                hold_write_r    <= dataE.ctl.memwrite;
                hold_regwrite_r <= dataE.ctl.regwrite;
                hold_dst_r      <= dataE.ctl.dst;
                dreq_valid_r    <= 1'b1;
            end else if (complete_s) begin
                dreq_valid_r    <= 1'b0;
            end else begin
                dreq_valid_r    <= dreq_valid_r;
            end
            data_m_r   <= data_m_next_s;
            valid_m_r  <= valid_m_next_s;
            misalign_r <= misalign_next_s;
        end
    end

    // Drive the bus request straight from the hold registers so every field
    // stays stable for the whole transaction.
    always_comb begin
        dreq.valid  = dreq_valid_r;
        dreq.addr   = hold_addr_r;
        dreq.size   = 3'b011;
        dreq.strobe = hold_strobe_r;
        dreq.data   = hold_wdata_r;
    end

    assign dataM    = data_m_r;
    assign valid_m  = valid_m_r;
    assign misalign = misalign_r;
    assign stall    = stall_s;
    // Jumps are resolved upstream; the bit is deliberately not consumed here.
    assign unused_s = dataE.ctl.jump;

endmodule

// File: doc/memory.md
Name: memory

Overview:
- Memory-access stage, directly downstream of the execute stage; consumes its `execute_data_t` output.
- Issues RV64 doubleword loads and stores on the data bus using a valid / addr_ok / data_ok handshake.
- Stalls upstream while a bus transaction is outstanding.
- Registers the result into `memory_data_t` for the writeback stage.
- Non-memory instructions pass through with one cycle of latency.

Parameters:
- `ALIGN_CHECK`, 1, when 1 a doubleword access with `addr[2:0]!=0` raises `misalign` and issues no bus request; when 0 no check is made.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `dataE`  in  execute_data_t  result[63:0] (address or ALU value), memdata[63:0] (store data), ctl.{memread, memwrite, regwrite, dst[4:0], jump}
- `valid_e`  in  1  `dataE` holds a live instruction this cycle
- `dreq`  out  dbus_req_t  valid, addr[63:0], size[2:0], strobe[7:0], data[63:0]
- `dresp`  in  dbus_resp_t  addr_ok, data_ok, data[63:0]
- `dataM`  out  memory_data_t  result[63:0], ctl.regwrite, ctl.dst[4:0] (registered)
- `valid_m`  out  1  `dataM` is live (registered)
- `stall`  out  1  upstream must hold `dataE` this cycle (combinational)
- `misalign`  out  1  one-cycle pulse on a misaligned access (registered)

Behaviour:
- Reset values: state=IDLE, `dreq.valid`=0, `valid_m`=0, `dataM`=0, `misalign`=0, hold registers=0.
- FSM states: IDLE, ADDR, DATA.
- IDLE, `valid_e`=1, memread=memwrite=0:
  - register `dataE.result`, regwrite and dst into `dataM`; `valid_m`=1 next cycle.
  - `stall`=0.
- IDLE, `valid_e`=1, memread|memwrite=1, aligned:
  - latch into hold registers: addr=result, wdata=memdata, write=memwrite, regwrite, dst.
  - `stall`=1; next state ADDR; `valid_m`=0 next cycle.
- IDLE, misaligned (`ALIGN_CHECK`=1):
  - no bus request; `misalign`=1 next cycle.
  - `valid_m`=1 next cycle with regwrite forced to 0.
  - `stall`=0.
- `valid_e`=0 in IDLE: `valid_m`=0 next cycle.
- ADDR and DATA drive `dreq` from the hold registers:
  - `dreq.valid`=1, `addr`=hold addr, `size`=3'b011 (8 bytes).
  - `strobe`=8'hFF for a store, 8'h00 for a load; `data`=hold wdata.
  - all `dreq` fields stay stable until the data_ok cycle.
- ADDR transitions:
  - `addr_ok`=1, `data_ok`=0 -> DATA.
  - `addr_ok`=1, `data_ok`=1 -> complete.
  - otherwise stay in ADDR.
- DATA transitions: `data_ok`=1 -> complete; otherwise stay in DATA.
- `data_ok` without `addr_ok` while in ADDR: treat as complete (bus guarantees ordering).
- Complete cycle:
  - `dataM.result` = `dresp.data` for a load, hold addr for a store.
  - regwrite and dst come from the hold registers.
  - `valid_m`=1 next cycle; next state IDLE.
  - `stall`=0 in the complete cycle so upstream advances.
- `stall`:
  - =1 in IDLE when a memory op is accepted.
  - =1 in ADDR and DATA except the complete cycle.
  - =0 otherwise.
- While in ADDR or DATA, `dataE` and `valid_e` are ignored; upstream holds them under `stall`.
- Load latency equals the bus latency plus 1 cycle; minimum total is 2 cycles from acceptance to `valid_m`.
- Reset asserted mid-transaction:
  - next cycle state=IDLE and `dreq.valid`=0.
  - no `valid_m` is produced for the aborted access.
  - a late `data_ok` arriving in IDLE is ignored.
- `ctl.jump` is not forwarded; it is resolved upstream.

Test Plan:
- ALU op: `valid_e`=1, result=64'h1234, regwrite=1, dst=5 -> next cycle `valid_m`=1, `dataM.result`=64'h1234, dst=5; `stall`=0 throughout.
- Load, 0-wait bus: addr 64'h8000_0010; `addr_ok` and `data_ok` both high in the first ADDR cycle with data=64'hDEAD_BEEF -> `stall` high for exactly 1 cycle; `dataM.result`=64'hDEAD_BEEF, `valid_m`=1, 2 cycles after acceptance.
- Store, split handshake: memdata=64'hA5A5; `addr_ok` 2 cycles after request, `data_ok` 3 cycles later -> `strobe`=8'hFF, `data`=64'hA5A5; `dreq` fields stable throughout; `stall` high for 6 cycles; `valid_m`=1 once.
- Misaligned load, addr 64'h8000_0003 -> `dreq.valid` never asserts; `misalign`=1 for 1 cycle; `valid_m`=1 with regwrite=0.
- Reset while in DATA -> `dreq.valid`=0 next cycle; a later `data_ok`=1 produces no `valid_m`; an ALU op issued next is handled normally.
- Back-to-back load then ALU op with upstream honouring `stall` -> two `valid_m` pulses in order; the ALU result is not lost or duplicated.
